// File: rtl/bus_mem_slave.sv
// rtl/bus_mem_slave.sv - word-addressed register memory responder with programmable wait states
module bus_mem_slave #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 'h0000_1000,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA    = 'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  req,
  input  logic                  valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic [1:0]            last_txn,
  output logic [7:0]            err_count
);

  localparam int                    IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(4 * DEPTH);
  localparam logic [3:0]            WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'b00,
    BUS_READ  = 2'b01,
    BUS_WRITE = 2'b10,
    BUS_ERROR = 2'b11
  } bus_transaction_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RECOVER
  } state_t;

  state_t                state_q;
  state_t                state_nxt;
  logic                  accept;
  logic                  enter_resp;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic                  cap_we;

  logic [ADDR_WIDTH-1:0] eff_addr;
  logic [DATA_WIDTH-1:0] eff_wdata;
  logic                  eff_we;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  legal;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  bus_transaction_t      txn_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [7:0]            err_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; with zero wait states the accept edge is also the commit edge
  always_comb begin
    state_nxt  = state_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && valid) begin
          accept = 1'b1;
          if (WS != 4'd0) begin
            state_nxt = S_WAIT;
          end else begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP:    state_nxt = S_RECOVER;
      S_RECOVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Capture the request and run the wait counter; bus inputs are ignored after accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_we    <= 1'b0;
      wait_cnt  <= 4'd0;
    end else if (accept) begin
      cap_addr  <= addr;
      cap_wdata <= wdata;
      cap_we    <= we;
      wait_cnt  <= WS;
    end else if (state_q == S_WAIT) begin
      wait_cnt  <= wait_cnt - 4'd1;
    end
  end

  // In IDLE the commit (zero-wait case) must use the live bus, otherwise the captured copy
  assign eff_addr  = (state_q == S_IDLE) ? addr  : cap_addr;
  assign eff_wdata = (state_q == S_IDLE) ? wdata : cap_wdata;
  assign eff_we    = (state_q == S_IDLE) ? we    : cap_we;

  assign offset = eff_addr - BASE_ADDR;
  assign legal  = (eff_addr[1:0] == 2'b00) && (eff_addr >= BASE_ADDR) && (offset < SPAN);
  assign idx    = offset[IDX_W+1:2];

  // Commit at the edge entering RESP: memory write, read data, status and error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata_q <= '0;
      txn_q   <= BUS_IDLE;
      err_q   <= 8'd0;
    end else if (enter_resp) begin
      if (legal) begin
        if (eff_we) begin
          mem[idx] <= eff_wdata;
          txn_q    <= BUS_WRITE;
        end else begin
          rdata_q  <= mem[idx];
          txn_q    <= BUS_READ;
        end
      end else begin
        if (!eff_we) begin
          rdata_q <= ERR_DATA;
        end
        txn_q <= BUS_ERROR;
        if (err_q != 8'hFF) begin
          err_q <= err_q + 8'd1;
        end
      end
    end
  end

  assign ack       = (state_q == S_RESP);
  assign rdata     = rdata_q;
  assign last_txn  = txn_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// tb/tb_bus_mem_slave.sv - scoreboard bench for bus_mem_slave (default and zero-wait instances)
module tb_bus_mem_slave;

  logic        clk;
  logic        rst_n;

  logic [31:0] addr1, wdata1, rdata1;
  logic        we1, req1, valid1, ack1;
  logic [1:0]  txn1;
  logic [7:0]  errc1;

  logic [31:0] addr0, wdata0, rdata0;
  logic        we0, req0, valid0, ack0;
  logic [1:0]  txn0;
  logic [7:0]  errc0;

  int total = 0;
  int bad   = 0;
  bit sel   = 1'b0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  txn;
    bit          chk_rdata;
  } exp_t;

  exp_t sb[$];

  bus_mem_slave dut (
    .clk(clk), .rst_n(rst_n), .addr(addr1), .wdata(wdata1), .we(we1),
    .req(req1), .valid(valid1), .rdata(rdata1), .ack(ack1),
    .last_txn(txn1), .err_count(errc1)
  );

  bus_mem_slave #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .addr(addr0), .wdata(wdata0), .we(we0),
    .req(req0), .valid(valid0), .rdata(rdata0), .ack(ack0),
    .last_txn(txn0), .err_count(errc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic r, input logic v);
    if (sel) begin
      addr0 = a; we0 = w; wdata0 = d; req0 = r; valid0 = v;
    end else begin
      addr1 = a; we1 = w; wdata1 = d; req1 = r; valid1 = v;
    end
  endtask

  function automatic logic cur_ack();
    return sel ? ack0 : ack1;
  endfunction

  // One request; bus is scrambled after accept to show captured fields are used
  task automatic run_txn(input string tag, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [31:0] er,
                         input logic [1:0] et, input bit chk, input int exp_lat);
    exp_t e;
    int   lat;
    sb.push_back('{rdata: er, txn: et, chk_rdata: chk});
    @(negedge clk);
    set_bus(a, w, d, 1'b1, 1'b1);
    @(negedge clk);
    set_bus(32'h0000_3000, ~w, ~d, 1'b0, 1'b0);
    lat = 1;
    while (!cur_ack() && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_rdata) check({tag, "_rdata"}, sel ? rdata0 : rdata1, e.rdata);
      check({tag, "_txn"}, 32'(sel ? txn0 : txn1), 32'(e.txn));
    end
    @(negedge clk);
    check({tag, "_ack_one_cycle"}, 32'(cur_ack()), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   highs;
    rst_n = 1'b0;
    set_bus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    sel = 1'b1;
    set_bus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    sel = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack1), 32'd0);
    check("rst_rdata", rdata1, 32'd0);
    check("rst_txn", 32'(txn1), 32'd0);
    check("rst_err", 32'(errc1), 32'd0);
    rst_n = 1'b1;

    // Write then read back
    run_txn("wr1004", 32'h1004, 1'b1, 32'hA5A5_0001, 32'h0, 2'b10, 1'b0, 2);
    run_txn("rd1004", 32'h1004, 1'b0, 32'h0, 32'hA5A5_0001, 2'b01, 1'b1, 2);

    // Out-of-range read and misaligned write
    run_txn("rd2000", 32'h2000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b1, 2);
    check("err_after_1", 32'(errc1), 32'd1);
    run_txn("wr1002", 32'h1002, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 2'b11, 1'b1, 2);
    check("err_after_2", 32'(errc1), 32'd2);
    run_txn("rd1000", 32'h1000, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 2);
    run_txn("rd_last_word", 32'h103C, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 2);
    run_txn("rd_past_end", 32'h1040, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b1, 2);
    run_txn("rd_below_base", 32'h0FFC, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b1, 2);
    check("err_after_4", 32'(errc1), 32'd4);

    // req/valid held high: accepts every 4 cycles
    repeat (3) sb.push_back('{rdata: 32'h0, txn: 2'b01, chk_rdata: 1'b1});
    @(negedge clk);
    set_bus(32'h1008, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("hold_ack_k%0d", k), 32'(ack1), 32'((k == 2) || (k == 6) || (k == 10)));
      if (ack1 && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("hold_rdata_k%0d", k), rdata1, e.rdata);
        check($sformatf("hold_txn_k%0d", k), 32'(txn1), 32'(e.txn));
      end
      if (k == 11) set_bus(32'h1008, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
    end
    check("hold_sb_empty", 32'(sb.size()), 32'd0);

    // req without valid is never accepted
    set_bus(32'h1004, 1'b0, 32'h0, 1'b1, 1'b0);
    highs = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack1) highs++;
    end
    check("noval_ack", 32'(highs), 32'd0);
    set_bus(32'h1004, 1'b0, 32'h0, 1'b0, 1'b0);

    // Address changes to 0x3000 during WAIT inside run_txn
    run_txn("rd_glitch", 32'h1004, 1'b0, 32'h0, 32'hA5A5_0001, 2'b01, 1'b1, 2);
    check("glitch_err", 32'(errc1), 32'd4);

    // Reset in the middle of a write
    run_txn("wr1000", 32'h1000, 1'b1, 32'h5, 32'h0, 2'b10, 1'b0, 2);
    @(negedge clk);
    set_bus(32'h1004, 1'b1, 32'h7, 1'b1, 1'b1);
    @(negedge clk);
    set_bus(32'h1004, 1'b1, 32'h7, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_ack_wait", 32'(ack1), 32'd0);
    @(negedge clk);
    check("midrst_ack_resp", 32'(ack1), 32'd0);
    rst_n = 1'b1;
    check("midrst_err", 32'(errc1), 32'd0);
    check("midrst_txn", 32'(txn1), 32'd0);
    run_txn("rd1000_cleared", 32'h1000, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 2);
    run_txn("rd1004_cleared", 32'h1004, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 2);

    // Reset while ack is high drops it at once
    @(negedge clk);
    set_bus(32'h1000, 1'b0, 32'h0, 1'b1, 1'b1);
    @(negedge clk);
    set_bus(32'h1000, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("resp_ack_before_rst", 32'(ack1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("resp_ack_after_rst", 32'(ack1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait instance
    sel = 1'b1;
    check("ws0_rst_err", 32'(errc0), 32'd0);
    run_txn("ws0_wr", 32'h1000, 1'b1, 32'h11, 32'h0, 2'b10, 1'b0, 1);
    run_txn("ws0_rd", 32'h1000, 1'b0, 32'h0, 32'h11, 2'b01, 1'b1, 1);
    for (int i = 0; i < 300; i++) begin
      run_txn($sformatf("ws0_err%0d", i), 32'h2000, 1'b0, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b1, 1);
      check($sformatf("ws0_errcnt%0d", i), 32'(errc0), (i < 255) ? 32'(i + 1) : 32'd255);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Responder end of the bus_if protocol: the slave-side block a CPU master talks to through the bus_if slave modport.
- Implements a small word-addressed register memory with a programmable number of wait states.
- Flags out-of-range and misaligned accesses as errors.
- Reports the class of the last completed transaction as a bus_transaction_t code and counts error responses.

Parameters:
- ADDR_WIDTH, 32: bus address width.
- DATA_WIDTH, 32: bus data width; one memory word equals DATA_WIDTH bits.
- DEPTH, 16: number of memory words; power of 2, at least 2.
- BASE_ADDR, 32'h0000_1000: byte address of word 0; aligned to 4*DEPTH.
- WAIT_STATES, 1: extra cycles between accept and ack; legal range 0..15.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on an errored read.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  ADDR_WIDTH  byte address from master.
- wdata  input  DATA_WIDTH  write data.
- we  input  1  1 = write, 0 = read.
- req  input  1  request strobe.
- valid  input  1  qualifies req; a request is presented only when req and valid are both 1.
- rdata  output  DATA_WIDTH  read response data.
- ack  output  1  one-cycle response strobe.
- last_txn  output  2  bus_transaction_t of the last completed transaction.
- err_count  output  8  saturating count of error responses.

Behaviour:
- Reset (async assert, sync release): ack=0, rdata=0, last_txn=BUS_IDLE (2'b00), err_count=0, FSM=IDLE, all memory words cleared to 0.
- FSM states: IDLE, WAIT, RESP, RECOVER.
- IDLE:
  - If req&&valid is sampled at a rising edge, capture addr, we and wdata, and load the wait counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else go to RESP.
- WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0. Bus inputs are ignored; captured fields are used.
- Latency: request sampled in cycle N gives ack=1 in exactly cycle N+1+WAIT_STATES, for one cycle only.
- Commit at the edge entering RESP, using the captured fields:
  - Legal write: mem[idx] <= wdata; rdata unchanged; last_txn <= BUS_WRITE (2'b10).
  - Legal read: rdata <= mem[idx]; last_txn <= BUS_READ (2'b01).
  - Error: no memory write; a read returns rdata <= ERR_DATA (a write leaves rdata unchanged); last_txn <= BUS_ERROR (2'b11); err_count increments, saturating at 255.
- Legality:
  - Legal means addr[1:0]==0 and BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
  - idx = (addr - BASE_ADDR) >> 2.
  - Misaligned or out-of-range accesses are errors; both reads and writes can error.
- RESP: ack=1; go to RECOVER next.
- RECOVER:
  - ack=0 and req is ignored for this one cycle; the master drops req on seeing ack.
  - Go to IDLE.
  - Minimum spacing between accepts is WAIT_STATES+3 cycles.
- rdata holds its value between read responses. last_txn holds until the next completion.
- req or valid dropping during WAIT/RESP does not abort the transaction; it completes and is acked.
- req=1 with valid=0 is never accepted.
- Reset mid-transaction: ack drops immediately, no commit occurs, memory is cleared.

Test Plan (defaults unless noted; request presented in cycle N):
- Write 0x1004 <= 32'hA5A5_0001 -> ack=1 in cycle N+2 only, last_txn=2'b10; then read 0x1004 -> ack in N'+2 with rdata=32'hA5A5_0001, last_txn=2'b01.
- Read 0x2000, then write 0x1002 -> both acked at N+2; the read returns rdata=32'hDEAD_BEEF; last_txn=2'b11; err_count goes 1 then 2; read of 0x1000 still returns 0.
- req=valid=1 held constant with read 0x1008 -> accepts at N, N+4, N+8; ack in N+2, N+6, N+10 and low in all other cycles.
- req=1, valid=0 for 10 cycles -> ack never asserted. Then a legal read whose addr is changed to 0x3000 during WAIT -> completes as the original address, no error.
- Write 0x1000 <= 5, then rst_n low during WAIT of a second write -> ack=0 immediately; after release, read 0x1000 returns 0 and err_count=0.
- WAIT_STATES=0 instance: ack in cycle N+1; 300 back-to-back errored reads -> err_count=255 after the 255th error and stays 255.
